// File: rtl/mul_sequencer.sv
// Iterative shift-add sequencer for the RV32M multiply path, driving an external 33-bit add/sub stage.
// Optional build macro: MUL_ZERO_SKIP_EN (zero operand bypasses the iteration and completes immediately).
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs1,
  input  logic [WIDTH-1:0] rs2,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH:0]   add_M,
  output logic [WIDTH:0]   add_A,
  output logic             add_sub,
  output logic             add_en,
  input  logic [WIDTH:0]   add_S,
  input  logic             add_x
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

  state_t         state, state_n;
  op_t            op_q, op_n;
  logic [WIDTH:0] m_q, m_n;
  logic [WIDTH:0] a_q, a_n;
  logic [WIDTH:0] b_q, b_n;
  logic [CW-1:0]  count_q, count_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic [WIDTH-1:0] word;
  logic           last;

  assign last  = (count_q == CW'(WIDTH));
  // {A,B} holds the 2*WIDTH+2 bit product; the high word straddles the A/B boundary.
  assign word  = (op_q == OP_MUL) ? b_q[WIDTH-1:0] : {a_q[WIDTH-2:0], b_q[WIDTH]};
  assign add_M = m_q;
  assign add_A = a_q;
  assign result = valid ? word : result_q;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state;
    op_n     = op_q;
    m_n      = m_q;
    a_n      = a_q;
    b_n      = b_q;
    count_n  = count_q;
    result_n = result_q;
    ready    = 1'b0;
    valid    = 1'b0;
    add_en   = 1'b0;
    add_sub  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          op_n    = op_t'(op);
          m_n     = {((op == OP_MULH) || (op == OP_MULHSU)) & rs1[WIDTH-1], rs1};
          b_n     = {(op == OP_MULH) & rs2[WIDTH-1], rs2};
          a_n     = '0;
          count_n = '0;
          state_n = CALC;
`ifdef MUL_ZERO_SKIP_EN
          if ((rs1 == '0) || (rs2 == '0)) begin
            b_n     = '0;
            state_n = DONE;
          end
`endif
        end
      end
      CALC: begin
        // The final multiplier bit is the extended sign, so its weight is subtracted.
        add_en  = b_q[0];
        add_sub = b_q[0] & last;
        a_n     = {add_x, add_S[WIDTH:1]};
        b_n     = {add_S[0], b_q[WIDTH:1]};
        count_n = count_q + CW'(1);
        if (last) state_n = DONE;
      end
      DONE: begin
        valid    = 1'b1;
        result_n = word;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= OP_MUL;
      m_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      m_q      <= m_n;
      a_q      <= a_n;
      b_q      <= b_n;
      count_q  <= count_n;
      result_q <= result_n;
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: models the external 33-bit adder, runs a vector table
// through a result scoreboard, then exercises ignored-start and mid-operation reset.
module tb_mul_sequencer;

  localparam int W = 32;
`ifdef MUL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs1, rs2;
  logic         ready, valid;
  logic [W-1:0] result;
  logic [W:0]   add_M, add_A, add_S;
  logic         add_sub, add_en, add_x;

  mul_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .ready(ready), .valid(valid), .result(result),
    .add_M(add_M), .add_A(add_A), .add_sub(add_sub), .add_en(add_en),
    .add_S(add_S), .add_x(add_x)
  );

  always #5 Clk = ~Clk;

  // External adder: signed 33-bit A +/- M into 34 bits; x is the true sign of that sum.
  logic [W+1:0] sum34;
  always_comb begin
    sum34 = {add_A[W], add_A};
    if (add_en) sum34 = add_sub ? sum34 - {add_M[W], add_M} : sum34 + {add_M[W], add_M};
  end
  assign add_S = sum34[W:0];
  assign add_x = sum34[W+1];

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [W-1:0] exp;
  } vec_t;

  vec_t         vecs [13];
  logic [W-1:0] sb_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] x, y, p;
    x = (o == 2'd1 || o == 2'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    y = (o == 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p = x * y;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e, input int glitch_at);
    int edges, en_cnt, sub_cnt, bad_ready, bad_sub;
    bit skip;
    logic [W:0]   bx;
    logic [W-1:0] exp_r;
    skip = SKIP && ((a == '0) || (b == '0));
    bx   = {(o == 2'd1) & b[31], b};
    edges = 0;
    while (!ready && edges < 100) begin @(negedge Clk); edges++; end
    check("ready_before_start", 64'(ready), 64'd1);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    sb_q.push_back(e);
    @(negedge Clk);
    start = 1'b0; op = ~o; rs1 = ~a; rs2 = ~b;
    edges = 1; en_cnt = 0; sub_cnt = 0; bad_ready = 0; bad_sub = 0;
    while (!valid && edges < 100) begin
      en_cnt  += int'(add_en);
      sub_cnt += int'(add_sub);
      if (add_sub && !add_en) bad_sub++;
      if (ready) bad_ready++;
      if (edges == glitch_at) begin
        start = 1'b1; op = 2'd3; rs1 = 32'hdeadbeef; rs2 = 32'h5;
      end else start = 1'b0;
      @(negedge Clk);
      edges++;
    end
    start = 1'b0;
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    check("latency", 64'(edges), skip ? 64'd1 : 64'd34);
    check("result", 64'(result), 64'(exp_r));
    check("add_en_count", 64'(en_cnt), skip ? 64'd0 : 64'($countones(bx)));
    check("add_sub_count", 64'(sub_cnt), (skip || !bx[W]) ? 64'd0 : 64'd1);
    check("sub_without_en", 64'(bad_sub), 64'd0);
    check("ready_low_in_calc", 64'(bad_ready), 64'd0);
    @(negedge Clk);
    check("valid_one_cycle", 64'(valid), 64'd0);
    check("ready_after_done", 64'(ready), 64'd1);
    check("result_held", 64'(result), 64'(e));
  endtask

  initial begin
    int vcount;
    Reset = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    vecs[0]  = '{2'd0, 32'd6,        32'd7,        32'd42};
    vecs[1]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[2]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[3]  = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{2'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[5]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[6]  = '{2'd0, 32'd0,        32'h1234,     32'd0};
    vecs[7]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[8]  = '{2'd1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
    for (int i = 9; i < 13; i++) begin
      vecs[i].op  = 2'(i - 9);
      vecs[i].rs1 = $urandom;
      vecs[i].rs2 = $urandom;
      vecs[i].exp = ref_mul(vecs[i].op, vecs[i].rs1, vecs[i].rs2);
    end

    repeat (3) @(negedge Clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_add_en_sub", {62'd0, add_en, add_sub}, 64'd0);
    check("rst_add_M", 64'(add_M), 64'd0);
    check("rst_add_A", 64'(add_A), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 13; i++) run_op(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].exp, -1);

    // start pulsed at cycle 10 of CALC must be ignored
    run_op(2'd0, 32'd6, 32'd7, 32'd42, 10);
    check("glitch_no_second_op", 64'(ready), 64'd1);
    check("glitch_queue_empty", 64'(sb_q.size()), 64'd0);

    // reset at cycle 15 of an operation
    start = 1'b1; op = 2'd0; rs1 = 32'd3; rs2 = 32'd5;
    @(negedge Clk);
    start = 1'b0;
    repeat (14) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_add_en", 64'(add_en), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge Clk);
      vcount += int'(valid);
    end
    check("abort_no_valid", 64'(vcount), 64'd0);
    check("abort_result_stays", 64'(result), 64'd0);

    run_op(2'd3, 32'h12345678, 32'h9ABCDEF0, ref_mul(2'd3, 32'h12345678, 32'h9ABCDEF0), -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add sequencer for the RV32M multiply path, sitting directly around the 33-bit add/subtract stage. It sign/zero-extends operands to 33 bits, drives that adder's operand/accumulator/sub/enable inputs each cycle, and consumes its 33-bit sum `S` and sign-correct bit `x` to shift the partial product. After 33 iterations it returns the low or high 32 bits of the 66-bit product for MUL/MULH/MULHSU/MULHU.

## Interface
- `WIDTH`, 32, operand width; the adder datapath is `WIDTH+1` bits.
- `Clk` input 1: sole clock, rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: request; accepted only while `ready`=1.
- `op` input 2: 00 MUL (low word), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- `rs1`, `rs2` input WIDTH: multiplicand, multiplier.
- `ready` output 1: high in IDLE only.
- `valid` output 1: one-cycle pulse, `result` is final.
- `result` output WIDTH: product word; held until next accepted `start`.
- `add_M` output WIDTH+1: multiplicand to adder `Switches`.
- `add_A` output WIDTH+1: accumulator to adder `A`.
- `add_sub` output 1: adder `sub`.
- `add_en` output 1: adder `outputEnable`.
- `add_S` input WIDTH+1: adder sum.
- `add_x` input 1: adder sign-correct MSB.

## Operation
- Registers: M (33b), A (33b), B (33b), count (6b), op_q (2b), state, result.
- Extension at accept: M = {rs1 sign if op∈{01,10} else 0, rs1}; B = {rs2 sign if op=01 else 0, rs2}; A = 0; count = 0; op_q = op.
- FSM IDLE → CALC on accepted `start`; CALC → DONE after iteration with count = WIDTH; DONE → IDLE unconditionally.
- CALC iteration (one per cycle): `add_en` = B[0]; `add_sub` = B[0] & (count == WIDTH) (subtract on extended sign bit); `add_A` = A, `add_M` = M. Register A ← {add_x, add_S[32:1]}, B ← {add_S[0], B[32:1]}, count ← count+1.
- `add_sub` is never high when `add_en` is low (adder would otherwise add 1); outside CALC `add_en`=`add_sub`=0.
- DONE: product P = {A,B} (66b); `result` ← P[31:0] if op_q=00 else P[63:32]; `valid`=1.
- `start` while not `ready` is ignored, no queuing; `op`/`rs1`/`rs2` sampled only at acceptance.

## Timing
- Reset values: `ready`=1, `valid`=0, `result`=0, `add_en`=0, `add_sub`=0, `add_M`=0, `add_A`=0; state IDLE, all registers 0.
- `start` accepted on edge E0; CALC iterations on E1..E33; `valid` high for the cycle following E34 edge... precisely: state DONE after E33, `valid` high and `result` updated during cycle E33→E34; `ready` returns after E34.
- Latency start→valid: 34 cycles; throughput: one op per 35 cycles (start may be asserted the cycle `ready` rises).
- Reset asserted mid-operation: immediate return to IDLE, no `valid`, `result`=0.
- Adder is combinational; the S/x path is single-cycle, no retiming.

## Configuration
- `MUL_ZERO_SKIP_EN` defined: if rs1 == 0 or rs2 == 0 at acceptance, FSM goes IDLE → DONE directly with A=B=0; `valid` on the cycle after acceptance, `result`=0, no adder activity.
- Undefined: every operation takes full 34-cycle latency regardless of operands.

## Test plan
- Reset, then MUL rs1=6, rs2=7 → `valid` 34 cycles after start, `result`=42; `ready` low throughout CALC.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → `result`=0x00000000; MUL same operands → 0x00000001.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- MULH 0x80000000 × 0x80000000 → 0x40000000; check `add_sub`=1 only at count=32 with B[0]=1.
- `start` pulsed at cycle 10 of CALC with different operands → ignored, first result unchanged; Reset at cycle 15 → `ready`=1, `result`=0, no `valid`.
- With `MUL_ZERO_SKIP_EN`: MUL 0 × 0x1234 → `valid` 1 cycle after start, `result`=0; without: 34 cycles, `result`=0.
